// File: rtl/key_debounce_if.sv
// Button conditioner signal bundle: raw pin in, debounced level and event pulses out.
// master = key_debounce (drives events); slave = consumer (drives the pin, reads events).
interface key_debounce_if;
   logic key_in;
   logic key_level;
   logic press_pulse;
   logic release_pulse;
   logic long_pulse;

   modport master (
      input  key_in,
      output key_level,
      output press_pulse,
      output release_pulse,
      output long_pulse
   );

   modport slave (
      output key_in,
      input  key_level,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse
   );
endinterface

// File: rtl/key_debounce.sv
// Push-button debouncer: press/release pulses DEBOUNCE_CYCLES+3 edges after the pin settles, no backpressure.
// Long-press detection (long_pulse) is compiled in only when KEY_LONGPRESS_EN is defined.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 50_000_000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   key_debounce_if.master kif
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic IDLE_PIN = ACTIVE_LOW;

   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
      $error("key_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
   end

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_e;

   logic [1:0]    sync_q;
   logic          key_s;
   state_e        state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          rel_q, rel_d;

`ifdef KEY_LONGPRESS_EN
   localparam int LW = $clog2(LONG_CYCLES);
   localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);
   logic [LW-1:0] lcnt_q, lcnt_d;
   logic          long_done_q, long_done_d;
   logic          long_q, long_d;
`endif

   // Synchronizer resets to the released level so reset never fakes a press edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {2{IDLE_PIN}};
      end else begin
         sync_q <= {sync_q[0], kif.key_in};
      end
   end

   assign key_s = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dcnt_q  <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
`ifdef KEY_LONGPRESS_EN
         lcnt_q      <= '0;
         long_done_q <= 1'b0;
         long_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
`ifdef KEY_LONGPRESS_EN
         lcnt_q      <= lcnt_d;
         long_done_q <= long_done_d;
         long_q      <= long_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
`ifdef KEY_LONGPRESS_EN
      lcnt_d      = lcnt_q;
      long_done_d = long_done_q;
      long_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (key_s) begin
               state_d = PRESS_WAIT;
               dcnt_d  = '0;
            end
         end
         PRESS_WAIT: begin
            if (!key_s) begin
               state_d = IDLE;
               dcnt_d  = '0;
            end else if (dcnt_q == D_LAST) begin
               state_d = PRESSED;
               press_d = 1'b1;
               level_d = 1'b1;
`ifdef KEY_LONGPRESS_EN
               lcnt_d      = '0;
               long_done_d = 1'b0;
`endif
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         PRESSED: begin
            // Release wins over a long-press that would fire this same cycle.
            if (!key_s) begin
               state_d = RELEASE_WAIT;
               dcnt_d  = '0;
            end else begin
`ifdef KEY_LONGPRESS_EN
               if (lcnt_q == L_LAST) begin
                  if (!long_done_q) begin
                     long_d      = 1'b1;
                     long_done_d = 1'b1;
                  end
               end else begin
                  lcnt_d = lcnt_q + 1'b1;
               end
`endif
            end
         end
         RELEASE_WAIT: begin
            if (key_s) begin
               state_d = PRESSED;
            end else if (dcnt_q == D_LAST) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               level_d = 1'b0;
`ifdef KEY_LONGPRESS_EN
               lcnt_d = '0;
`endif
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            dcnt_d  = '0;
         end
      endcase
   end

   assign kif.key_level     = level_q;
   assign kif.press_pulse   = press_q;
   assign kif.release_pulse = rel_q;
`ifdef KEY_LONGPRESS_EN
   assign kif.long_pulse = long_q;
`else
   assign kif.long_pulse = 1'b0;
`endif

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces and conditions a raw mechanical push-button pin into clean one-cycle event pulses. It sits directly upstream of the buzzer tone generator: `press_pulse` drives the tone generator's key input, so each debounced press produces exactly one beep request. Other consumers can use the level, release and long-press outputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the input must be stable before a level change is accepted (20 ms at 50 MHz). Must be ≥ 2.
- `LONG_CYCLES`, default 50_000_000: cycles held in PRESSED before `long_pulse` fires (1 s at 50 MHz). Must be > `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed; 0 means the pin reads 1 when pressed.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_in` in 1: raw button pin, asynchronous to `clk`.
- `key_level` out 1: debounced state; 1 = pressed.
- `press_pulse` out 1: one-cycle pulse on an accepted press.
- `release_pulse` out 1: one-cycle pulse on an accepted release.
- `long_pulse` out 1: one-cycle pulse when a press has been held `LONG_CYCLES` cycles.

## Operation
- **Input conditioning:** 2-flop synchronizer on `key_in`. Both flops reset to the pin's idle (released) level. The synchronized value is polarity-normalized to `key_s` (1 = pressed).
- **Counter widths:** the debounce counter is `$clog2(DEBOUNCE_CYCLES)` bits; the long counter is `$clog2(LONG_CYCLES)` bits. Neither counter ever wraps.
- **FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- **IDLE:** if `key_s`=1, go to PRESS_WAIT with the debounce counter = 0.
- **PRESS_WAIT:**
  - `key_s`=0: return to IDLE and clear the counter (glitch rejected).
  - `key_s`=1 and counter == `DEBOUNCE_CYCLES`-1: go to PRESSED, assert `press_pulse`, set `key_level`=1, long counter = 0.
  - Otherwise increment the counter.
- **PRESSED:**
  - `key_s`=0: go to RELEASE_WAIT with the debounce counter = 0. Release has priority; no `long_pulse` is issued in this cycle.
  - Otherwise the long counter increments. When it equals `LONG_CYCLES`-1, assert `long_pulse` once and saturate. At most one `long_pulse` per press.
- **RELEASE_WAIT:** the long counter is frozen.
  - `key_s`=1: return to PRESSED (bounce). No pulses; `key_level` stays 1; the long counter resumes from its held value.
  - `key_s`=0 and debounce counter == `DEBOUNCE_CYCLES`-1: go to IDLE, assert `release_pulse`, set `key_level`=0, clear the long counter.
  - Otherwise increment the debounce counter.
- **Pulse exclusivity:** `press_pulse`, `release_pulse` and `long_pulse` are registered and mutually exclusive in any cycle.

## Timing
- **Reset values:** every output = 0, state = IDLE, counters = 0.
- **Reset mid-operation:** the state is abandoned with no pulses. A key still held when reset deasserts is debounced from scratch and yields a fresh `press_pulse`.
- **Press latency:** edge 1 is the first `clk` edge that samples the pressed pin. `press_pulse` is high, and `key_level` rises, after edge `DEBOUNCE_CYCLES`+3.
- **Release latency:** `release_pulse` is high, and `key_level` falls, after edge `DEBOUNCE_CYCLES`+3, counted from the first edge sampling the released pin (bounce-free case).
- **Long-press latency:** `long_pulse` occurs exactly `LONG_CYCLES` edges after `press_pulse`, provided the key is held without bounce.
- **Glitch rejection:** any pressed or released excursion shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- **Pulse width:** every pulse output is exactly 1 cycle wide.

## Configuration
- **Macro:** `KEY_LONGPRESS_EN`.
- **Defined:** the long counter and `long_pulse` logic are compiled in as specified above.
- **Undefined:** the long counter is not instantiated, `long_pulse` is tied to 0, and `LONG_CYCLES` is ignored. All other behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `ACTIVE_LOW`=1, `KEY_LONGPRESS_EN` defined unless noted.
1. **Reset:** assert `rst_n`=0 with `key_in`=1 → all outputs 0; they stay 0 for 50 cycles after release.
2. **Clean press:** `key_in` 1→0 held 40 cycles → `press_pulse` 1 cycle after edge 7; `key_level`=1 from edge 7; `long_pulse` 1 cycle after edge 27; exactly one of each.
3. **Glitch:** `key_in` low for 3 cycles, then high → no pulses, `key_level` stays 0.
4. **Release bounce, then release:** while pressed, drive `key_in` high 2 cycles then low → no `release_pulse`, `key_level` stays 1. Then drive high and hold → `release_pulse` after edge 7 relative to the first high sample; `key_level`→0.
5. **Reset mid-press:** pulse `rst_n` low while `key_in` is held 0 in PRESSED → outputs 0 immediately; `press_pulse` re-fires 7 edges after the first post-reset edge.
6. **Macro undefined:** hold the key 40 cycles → `press_pulse` behaves as in scenario 2; `long_pulse` never asserts.
